// File: rtl/idex_fwd_stage.sv
// ID/EX pipeline register with load-use stall detection and EX-side operand forwarding.
// Optional perf counters are built only when IDEX_PERF_EN is defined.
`default_nettype none

module idex_fwd_stage #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RAW-1:0]  id_rs1,
  input  logic [RAW-1:0]  id_rs2,
  input  logic [RAW-1:0]  id_rd,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [4:0]      id_aluop,
  input  logic            id_asel_pc,
  input  logic            id_bsel_imm,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic [1:0]      id_wdsel,
  input  logic            ex_flush,
  input  logic [RAW-1:0]  exm_rd,
  input  logic            exm_regwrite,
  input  logic [XLEN-1:0] exm_result,
  input  logic [RAW-1:0]  mwb_rd,
  input  logic            mwb_regwrite,
  input  logic [XLEN-1:0] mwb_wdata,
  output logic            stall,
  output logic [XLEN-1:0] alu_A,
  output logic [XLEN-1:0] alu_B,
  output logic [4:0]      alu_op,
  output logic            ex_valid,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic [RAW-1:0]  ex_rd,
  output logic [1:0]      ex_wdsel,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_store_data,
  output logic [31:0]     perf_bubbles,
  output logic [31:0]     perf_flushes
);

  // Same encoding as `ALUOp_add in ctrl_encode_def.v; add never raises a branch flush.
  localparam logic [4:0] ALUOP_ADD = 5'b00011;

  logic [RAW-1:0]  rs1_q;
  logic [RAW-1:0]  rs2_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [4:0]      aluop_q;
  logic            asel_pc_q;
  logic            bsel_imm_q;

  logic            rs1_hit;
  logic            rs2_hit;
  logic            hazard;
  logic            load_bubble;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // Load-use: the load in EX has not produced data yet, so the ID consumer must wait.
  assign rs1_hit     = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit     = id_use_rs2 && (id_rs2 == ex_rd);
  assign hazard      = ex_valid && ex_memread && (ex_rd != '0) && (rs1_hit || rs2_hit);
  assign stall       = hazard && !ex_flush;
  assign load_bubble = ex_flush || hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || load_bubble) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_rd       <= '0;
      ex_wdsel    <= 2'b00;
      ex_pc       <= '0;
      ex_imm      <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      aluop_q     <= ALUOP_ADD;
      asel_pc_q   <= 1'b0;
      bsel_imm_q  <= 1'b0;
    end else begin
      ex_valid    <= id_valid;
      ex_regwrite <= id_regwrite;
      ex_memread  <= id_memread;
      ex_memwrite <= id_memwrite;
      ex_rd       <= id_rd;
      ex_wdsel    <= id_wdsel;
      ex_pc       <= id_pc;
      ex_imm      <= id_imm;
      rs1_q       <= id_rs1;
      rs2_q       <= id_rs2;
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
      aluop_q     <= id_aluop;
      asel_pc_q   <= id_asel_pc;
      bsel_imm_q  <= id_bsel_imm;
    end
  end

  // EX/MEM is younger than MEM/WB, so it wins; x0 always reads as the stored value.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (rs1_q != '0 && exm_regwrite && exm_rd == rs1_q) begin
      fwd_rs1 = exm_result;
    end else if (rs1_q != '0 && mwb_regwrite && mwb_rd == rs1_q) begin
      fwd_rs1 = mwb_wdata;
    end
  end

  always_comb begin
    fwd_rs2 = rs2_data_q;
    if (rs2_q != '0 && exm_regwrite && exm_rd == rs2_q) begin
      fwd_rs2 = exm_result;
    end else if (rs2_q != '0 && mwb_regwrite && mwb_rd == rs2_q) begin
      fwd_rs2 = mwb_wdata;
    end
  end

  assign alu_A         = asel_pc_q  ? ex_pc  : fwd_rs1;
  assign alu_B         = bsel_imm_q ? ex_imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign alu_op        = ex_valid ? aluop_q : ALUOP_ADD;

`ifdef IDEX_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_bubbles <= '0;
      perf_flushes <= '0;
    end else begin
      if (load_bubble) perf_bubbles <= perf_bubbles + 32'd1;
      if (ex_flush)    perf_flushes <= perf_flushes + 32'd1;
    end
  end
`else
  assign perf_bubbles = '0;
  assign perf_flushes = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_idex_fwd_stage.sv
// Self-checking bench for idex_fwd_stage: directed scenarios plus randomized traffic vs a reference model.
`default_nettype none

module tb_idex_fwd_stage;
  localparam logic [4:0] ADD = 5'b00011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid, id_use_rs1, id_use_rs2, id_asel_pc, id_bsel_imm;
  logic        id_regwrite, id_memread, id_memwrite, ex_flush, exm_regwrite, mwb_regwrite;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, exm_result, mwb_wdata;
  logic [4:0]  id_rs1, id_rs2, id_rd, id_aluop, exm_rd, mwb_rd;
  logic [1:0]  id_wdsel;
  logic        stall, ex_valid, ex_regwrite, ex_memread, ex_memwrite;
  logic [31:0] alu_A, alu_B, ex_pc, ex_imm, ex_store_data, perf_bubbles, perf_flushes;
  logic [4:0]  alu_op, ex_rd;
  logic [1:0]  ex_wdsel;

  int tests = 0;
  int fails = 0;

  idex_fwd_stage #(.XLEN(32), .RAW(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_aluop(id_aluop),
    .id_asel_pc(id_asel_pc), .id_bsel_imm(id_bsel_imm),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_wdsel(id_wdsel), .ex_flush(ex_flush),
    .exm_rd(exm_rd), .exm_regwrite(exm_regwrite), .exm_result(exm_result),
    .mwb_rd(mwb_rd), .mwb_regwrite(mwb_regwrite), .mwb_wdata(mwb_wdata),
    .stall(stall), .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_rd(ex_rd), .ex_wdsel(ex_wdsel),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_store_data(ex_store_data),
    .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction currently sitting in EX, as a record.
  typedef struct {
    bit        valid, regwrite, memread, memwrite, asel, bsel;
    bit [4:0]  rd, rs1, rs2, aluop;
    bit [1:0]  wdsel;
    bit [31:0] pc, imm, d1, d2;
  } slot_t;

  slot_t     m_ex;
  bit [31:0] m_bubbles = 0;
  bit [31:0] m_flushes = 0;

  function automatic slot_t empty_slot();
    slot_t s;
    s = '{default: 0};
    s.aluop = ADD;
    return s;
  endfunction

  function automatic bit m_hazard();
    return m_ex.valid && m_ex.memread && m_ex.rd != 0 &&
           ((id_use_rs1 && id_rs1 == m_ex.rd) || (id_use_rs2 && id_rs2 == m_ex.rd));
  endfunction

  function automatic bit [31:0] m_fwd(bit [4:0] r, bit [31:0] d);
    if (r != 0 && exm_regwrite && exm_rd == r) return exm_result;
    if (r != 0 && mwb_regwrite && mwb_rd == r) return mwb_wdata;
    return d;
  endfunction

  function automatic bit [31:0] exp_bub();
`ifdef IDEX_PERF_EN
    return m_bubbles;
`else
    return 32'd0;
`endif
  endfunction

  function automatic bit [31:0] exp_fl();
`ifdef IDEX_PERF_EN
    return m_flushes;
`else
    return 32'd0;
`endif
  endfunction

  initial m_ex = empty_slot();

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ex = empty_slot();
      m_bubbles = 0;
      m_flushes = 0;
    end else if (ex_flush || m_hazard()) begin
      m_ex = empty_slot();
      m_bubbles = m_bubbles + 1;
      if (ex_flush) m_flushes = m_flushes + 1;
    end else begin
      m_ex.valid = id_valid;       m_ex.regwrite = id_regwrite;
      m_ex.memread = id_memread;   m_ex.memwrite = id_memwrite;
      m_ex.asel = id_asel_pc;      m_ex.bsel = id_bsel_imm;
      m_ex.rd = id_rd;             m_ex.rs1 = id_rs1;   m_ex.rs2 = id_rs2;
      m_ex.aluop = id_aluop;       m_ex.wdsel = id_wdsel;
      m_ex.pc = id_pc;             m_ex.imm = id_imm;
      m_ex.d1 = id_rs1_data;       m_ex.d2 = id_rs2_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_aluop = ADD; id_asel_pc = 0; id_bsel_imm = 0;
    id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_wdsel = 0;
    ex_flush = 0; exm_rd = 0; exm_regwrite = 0; exm_result = 0;
    mwb_rd = 0; mwb_regwrite = 0; mwb_wdata = 0;
  endtask

  task automatic set_alu(input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
                         input bit [31:0] d1, input bit [31:0] d2);
    set_idle();
    id_valid = 1; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = 1; id_use_rs2 = 1; id_rs1_data = d1; id_rs2_data = d2;
    id_regwrite = 1; id_pc = 32'h100;
  endtask

  task automatic set_load(input bit [4:0] rd);
    set_idle();
    id_valid = 1; id_rd = rd; id_rs1 = 2; id_use_rs1 = 1; id_imm = 8;
    id_bsel_imm = 1; id_memread = 1; id_regwrite = 1; id_wdsel = 2'd1;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1;
    tick(); tick();
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", ex_valid); end
    tests++; if ({ex_regwrite, ex_memread, ex_memwrite} !== 3'b000) begin fails++; $display("FAIL reset_ctrl got %b want 000", {ex_regwrite, ex_memread, ex_memwrite}); end
    tests++; if (alu_op !== ADD) begin fails++; $display("FAIL reset_aluop got %h want %h", alu_op, ADD); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
    tests++; if ({ex_rd, ex_wdsel, ex_pc, ex_imm} !== '0) begin fails++; $display("FAIL reset_fields rd %h wdsel %h pc %h imm %h want 0", ex_rd, ex_wdsel, ex_pc, ex_imm); end
    tests++; if (perf_bubbles !== 32'd0 || perf_flushes !== 32'd0) begin fails++; $display("FAIL reset_perf got %0d/%0d want 0/0", perf_bubbles, perf_flushes); end
    rst = 0;
    tick();
  endtask

  task automatic test_plain_add();
    set_alu(5'd3, 5'd1, 5'd2, 32'd5, 32'd7);
    tick();
    set_idle();
    #1;
    tests++; if (alu_A !== 32'd5) begin fails++; $display("FAIL add_A got %h want 5", alu_A); end
    tests++; if (alu_B !== 32'd7) begin fails++; $display("FAIL add_B got %h want 7", alu_B); end
    tests++; if (ex_rd !== 5'd3 || ex_regwrite !== 1'b1 || ex_valid !== 1'b1) begin fails++; $display("FAIL add_ctrl got rd %0d rw %b v %b want 3 1 1", ex_rd, ex_regwrite, ex_valid); end
    tests++; if (alu_op !== ADD) begin fails++; $display("FAIL add_op got %h want %h", alu_op, ADD); end
  endtask

  task automatic test_forwarding();
    set_alu(5'd6, 5'd1, 5'd1, 32'h99, 32'h99);
    tick();
    set_idle();
    exm_rd = 1; exm_regwrite = 1; exm_result = 32'h10;
    mwb_rd = 1; mwb_regwrite = 1; mwb_wdata = 32'h20;
    #1;
    tests++; if (alu_A !== 32'h10) begin fails++; $display("FAIL fwd_exm_prio got %h want 10", alu_A); end
    tests++; if (ex_store_data !== 32'h10) begin fails++; $display("FAIL fwd_store got %h want 10", ex_store_data); end
    exm_regwrite = 0;
    #1;
    tests++; if (alu_A !== 32'h20) begin fails++; $display("FAIL fwd_mwb got %h want 20", alu_A); end
    mwb_regwrite = 0;
    #1;
    tests++; if (alu_A !== 32'h99) begin fails++; $display("FAIL fwd_none got %h want 99", alu_A); end
    set_alu(5'd7, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    set_idle();
    exm_rd = 0; exm_regwrite = 1; exm_result = 32'hDEAD;
    mwb_rd = 0; mwb_regwrite = 1; mwb_wdata = 32'hBEEF;
    #1;
    tests++; if (alu_A !== 32'h0) begin fails++; $display("FAIL fwd_x0 got %h want 0", alu_A); end
  endtask

  task automatic test_load_use();
    int stalls = 0;
    set_load(5'd4);
    tick();
    set_alu(5'd5, 5'd4, 5'd1, 32'h5555, 32'h1);
    #1;
    if (stall === 1'b1) stalls++;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_stall got %b want 1", stall); end
    tick();
    tests++; if (ex_valid !== 1'b0 || alu_op !== ADD) begin fails++; $display("FAIL lu_bubble got v %b op %h want 0 %h", ex_valid, alu_op, ADD); end
    if (stall === 1'b1) stalls++;
    mwb_rd = 4; mwb_regwrite = 1; mwb_wdata = 32'h1234;
    tick();
    if (stall === 1'b1) stalls++;
    tests++; if (stalls != 1) begin fails++; $display("FAIL lu_stall_len got %0d want 1", stalls); end
    tests++; if (ex_valid !== 1'b1 || ex_rd !== 5'd5) begin fails++; $display("FAIL lu_enter got v %b rd %0d want 1 5", ex_valid, ex_rd); end
    tests++; if (alu_A !== 32'h1234) begin fails++; $display("FAIL lu_fwd got %h want 1234", alu_A); end
    set_idle();
    tick();
  endtask

  task automatic test_flush_hazard();
    bit [31:0] b0, f0;
    set_load(5'd4);
    tick();
    set_alu(5'd5, 5'd4, 5'd1, 32'h1, 32'h2);
    ex_flush = 1;
    b0 = exp_bub(); f0 = exp_fl();
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL fh_stall got %b want 0", stall); end
    tick();
    ex_flush = 0;
    #1;
    tests++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_memread !== 1'b0) begin fails++; $display("FAIL fh_bubble got v %b rw %b mr %b want 000", ex_valid, ex_regwrite, ex_memread); end
`ifdef IDEX_PERF_EN
    tests++; if (perf_flushes !== f0 + 32'd1 || perf_bubbles !== b0 + 32'd1) begin fails++; $display("FAIL fh_perf got %0d/%0d want %0d/%0d", perf_bubbles, perf_flushes, b0 + 1, f0 + 1); end
`else
    tests++; if (perf_flushes !== 32'd0 || perf_bubbles !== 32'd0) begin fails++; $display("FAIL fh_perf got %0d/%0d want 0/0", perf_bubbles, perf_flushes); end
`endif
  endtask

  task automatic test_back_to_back();
    bit [31:0] f0;
    f0 = exp_fl();
    for (int i = 0; i < 3; i++) begin
      set_alu(5'(i + 8), 5'd1, 5'd2, 32'(i), 32'(i));
      id_aluop = 5'b00100;
      ex_flush = 1;
      tick();
      tests++; if (ex_valid !== 1'b0 || alu_op !== ADD) begin fails++; $display("FAIL b2b_flush%0d got v %b op %h want 0 %h", i, ex_valid, alu_op, ADD); end
    end
    ex_flush = 0;
    #1;
`ifdef IDEX_PERF_EN
    tests++; if (perf_flushes !== f0 + 32'd3) begin fails++; $display("FAIL b2b_perf got %0d want %0d", perf_flushes, f0 + 3); end
`else
    tests++; if (perf_flushes !== 32'd0 || perf_bubbles !== 32'd0) begin fails++; $display("FAIL b2b_perf got %0d/%0d want 0/0", perf_bubbles, perf_flushes); end
`endif
    set_idle();
    tick();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 400; c++) begin
      id_valid = $urandom_range(0, 3) != 0;
      id_pc = $urandom; id_imm = $urandom;
      id_rs1_data = $urandom; id_rs2_data = $urandom;
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7));
      id_use_rs1 = $urandom_range(0, 1); id_use_rs2 = $urandom_range(0, 1);
      id_aluop = 5'($urandom); id_asel_pc = $urandom_range(0, 1); id_bsel_imm = $urandom_range(0, 1);
      id_regwrite = $urandom_range(0, 1); id_memread = $urandom_range(0, 2) == 0;
      id_memwrite = $urandom_range(0, 1); id_wdsel = 2'($urandom);
      ex_flush = $urandom_range(0, 7) == 0;
      exm_rd = 5'($urandom_range(0, 7)); exm_regwrite = $urandom_range(0, 1); exm_result = $urandom;
      mwb_rd = 5'($urandom_range(0, 7)); mwb_regwrite = $urandom_range(0, 1); mwb_wdata = $urandom;
      #1;
      tests++;
      if (stall !== (m_hazard() && !ex_flush)) begin bad++; fails++; $display("FAIL rnd_stall c%0d got %b want %b", c, stall, m_hazard() && !ex_flush); end
      tests++;
      if (alu_A !== (m_ex.asel ? m_ex.pc : m_fwd(m_ex.rs1, m_ex.d1)) ||
          alu_B !== (m_ex.bsel ? m_ex.imm : m_fwd(m_ex.rs2, m_ex.d2)) ||
          ex_store_data !== m_fwd(m_ex.rs2, m_ex.d2)) begin
        fails++;
        $display("FAIL rnd_operands c%0d got A %h B %h S %h want A %h B %h S %h", c, alu_A, alu_B, ex_store_data,
                 m_ex.asel ? m_ex.pc : m_fwd(m_ex.rs1, m_ex.d1), m_ex.bsel ? m_ex.imm : m_fwd(m_ex.rs2, m_ex.d2), m_fwd(m_ex.rs2, m_ex.d2));
      end
      tests++;
      if (alu_op !== (m_ex.valid ? m_ex.aluop : ADD) || ex_valid !== m_ex.valid || ex_regwrite !== m_ex.regwrite ||
          ex_memread !== m_ex.memread || ex_memwrite !== m_ex.memwrite || ex_rd !== m_ex.rd ||
          ex_wdsel !== m_ex.wdsel || ex_pc !== m_ex.pc || ex_imm !== m_ex.imm) begin
        fails++;
        $display("FAIL rnd_ctrl c%0d got v%b rw%b mr%b mw%b rd%0d op%h want v%b rw%b mr%b mw%b rd%0d op%h", c,
                 ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_rd, alu_op,
                 m_ex.valid, m_ex.regwrite, m_ex.memread, m_ex.memwrite, m_ex.rd, m_ex.valid ? m_ex.aluop : ADD);
      end
      tests++;
      if (perf_bubbles !== exp_bub() || perf_flushes !== exp_fl()) begin fails++; $display("FAIL rnd_perf c%0d got %0d/%0d want %0d/%0d", c, perf_bubbles, perf_flushes, exp_bub(), exp_fl()); end
      tick();
      if (bad > 20) break;
    end
    set_idle();
    tick();
  endtask

  task automatic test_async_reset();
    set_load(5'd9);
    tick();
    set_idle();
    #2;
    rst = 1;
    #1;
    tests++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_memread !== 1'b0) begin fails++; $display("FAIL ar_ctrl got v %b rw %b mr %b want 000", ex_valid, ex_regwrite, ex_memread); end
    tests++; if (alu_op !== ADD || ex_rd !== 5'd0 || ex_imm !== 32'd0) begin fails++; $display("FAIL ar_fields got op %h rd %0d imm %h want %h 0 0", alu_op, ex_rd, ex_imm, ADD); end
    tests++; if (perf_bubbles !== 32'd0 || perf_flushes !== 32'd0) begin fails++; $display("FAIL ar_perf got %0d/%0d want 0/0", perf_bubbles, perf_flushes); end
    tick();
    rst = 0;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_plain_add();
    test_forwarding();
    test_load_use();
    test_flush_hazard();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
